// File: rtl/indikator2_pkg.sv
// Shared definitions for the MAX7219 serial driver: register map, state encodings
// and the power-up configuration sequence.
package indikator2_pkg;

  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIM   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_DISPTEST  = 8'h0F;

  localparam logic [2:0] NumInitFrames = 3'd5;

  typedef enum logic [1:0] {StWait, StInit, StIdle, StFrame} state_e;

  typedef enum logic [2:0] {TxIdle, TxLead, TxBits, TxTail, TxGuard} tx_state_e;

  // Configuration frame for a given sequence index; intensity is taken live.
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] level);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {REG_SHUTDOWN, 8'h01};
      3'd1:    w = {REG_DECODE, 8'hFF};
      3'd2:    w = {REG_SCANLIM, 8'h07};
      3'd3:    w = {REG_INTENSITY, 4'h0, level};
      default: w = {REG_DISPTEST, 8'h00};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/spi_tx16.sv
// 16-bit SPI frame shifter: one lead cycle, 16 two-cycle bits, one tail cycle,
// then a two-cycle chip-select-high guard before it accepts the next start.
module spi_tx16
  import indikator2_pkg::*;
(
  input  logic        clk_in,
  input  logic        init_n,
  input  logic        start,
  input  logic [15:0] word,
  output logic        busy,
  output logic        SPI_MOSI,
  output logic        SPI_CLK,
  output logic        SPI_CS
);

  tx_state_e   state_q;
  logic [15:0] word_q;
  logic [3:0]  bit_q;
  logic        phase_q;
  logic        cs_q, sclk_q, mosi_q;

  always_ff @(posedge clk_in) begin
    if (!init_n) begin
      state_q <= TxIdle;
      word_q  <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      unique case (state_q)
        TxIdle: begin
          if (start) begin
            word_q  <= word;
            cs_q    <= 1'b0;
            mosi_q  <= word[15];
            state_q <= TxLead;
          end
        end
        TxLead: begin
          bit_q   <= 4'd15;
          phase_q <= 1'b0;
          state_q <= TxBits;
        end
        TxBits: begin
          if (!phase_q) begin
            sclk_q  <= 1'b1;
            phase_q <= 1'b1;
          end else begin
            sclk_q  <= 1'b0;
            phase_q <= 1'b0;
            if (bit_q == 4'd0) begin
              state_q <= TxTail;
            end else begin
              bit_q  <= bit_q - 4'd1;
              mosi_q <= word_q[bit_q - 4'd1];
            end
          end
        end
        TxTail: begin
          cs_q    <= 1'b1;
          mosi_q  <= 1'b0;
          phase_q <= 1'b0;
          state_q <= TxGuard;
        end
        TxGuard: begin
          phase_q <= 1'b1;
          if (phase_q) state_q <= TxIdle;
        end
        default: state_q <= TxIdle;
      endcase
    end
  end

  assign busy     = (state_q != TxIdle);
  assign SPI_MOSI = mosi_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_CS   = cs_q;

endmodule

// File: rtl/indikator2.sv
// MAX7219 driver top: power-up delay, configuration sequence, then digit writes
// and intensity updates turned into SPI frames.
module indikator2
  import indikator2_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 1_250_000
) (
  input  logic       clk_in,
  input  logic       init_n,
  input  logic [3:0] data,
  input  logic [4:0] position,
  input  logic       wrn,
  input  logic [3:0] intensity,
  output logic       SPI_MOSI,
  output logic       SPI_CLK,
  output logic       SPI_CS,
  output logic       test_out
);

  localparam int unsigned DelayCycles = CLK_FREQ / 1000;
  localparam int unsigned DelayW      = $clog2(DelayCycles + 1);
  localparam logic [DelayW-1:0] DelayLoad = DelayW'(DelayCycles);

  state_e            state_q;
  logic [DelayW-1:0] dly_q;
  logic [2:0]        init_idx_q;
  logic              start_q;
  logic [15:0]       word_q;
  logic [3:0]        last_int_q;
  logic              buf_valid_q;
  logic [15:0]       buf_word_q;
  logic              tx_busy;

  always_ff @(posedge clk_in) begin
    if (!init_n) begin
      state_q     <= StWait;
      dly_q       <= DelayLoad;
      init_idx_q  <= '0;
      start_q     <= 1'b0;
      word_q      <= '0;
      last_int_q  <= '0;
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StWait: begin
          if (dly_q == '0) begin
            state_q    <= StInit;
            init_idx_q <= '0;
          end else begin
            dly_q <= dly_q - DelayW'(1);
          end
        end
        StInit: begin
          start_q    <= 1'b1;
          word_q     <= init_word(init_idx_q, intensity);
          if (init_idx_q == 3'd3) last_int_q <= intensity;
          init_idx_q <= init_idx_q + 3'd1;
          state_q    <= StFrame;
        end
        StIdle: begin
          // Pending digit write has priority over an intensity change.
          if (buf_valid_q) begin
            start_q     <= 1'b1;
            word_q      <= buf_word_q;
            buf_valid_q <= 1'b0;
            state_q     <= StFrame;
          end else if (intensity != last_int_q) begin
            start_q    <= 1'b1;
            word_q     <= {REG_INTENSITY, 4'h0, intensity};
            last_int_q <= intensity;
            state_q    <= StFrame;
          end
        end
        StFrame: begin
          // start_q is still high in the cycle before the shifter reports busy.
          if (!start_q && !tx_busy) begin
            state_q <= (init_idx_q < NumInitFrames) ? StInit : StIdle;
          end
        end
        default: state_q <= StWait;
      endcase

      // Placed last so a fresh write overrides the buffer clear in StIdle.
      if (!wrn && (position < 5'd8)) begin
        buf_valid_q <= 1'b1;
        buf_word_q  <= {REG_DIGIT0 + {5'b0, position[2:0]}, 4'h0, data};
      end
    end
  end

  spi_tx16 u_tx (
    .clk_in   (clk_in),
    .init_n   (init_n),
    .start    (start_q),
    .word     (word_q),
    .busy     (tx_busy),
    .SPI_MOSI (SPI_MOSI),
    .SPI_CLK  (SPI_CLK),
    .SPI_CS   (SPI_CS)
  );

  assign test_out = (state_q == StInit) || (state_q == StFrame) || start_q || tx_busy ||
                    buf_valid_q || ((state_q == StIdle) && (intensity != last_int_q));

endmodule

// File: tb/tb_indikator2.sv
// Self-checking bench for indikator2: an SPI monitor decodes frames and compares
// them against a queue of expected words pushed by the scenario tasks.
module tb_indikator2;

  logic       clk_in = 1'b0;
  logic       init_n;
  logic [3:0] data;
  logic [4:0] position;
  logic       wrn;
  logic [3:0] intensity;
  logic       SPI_MOSI, SPI_CLK, SPI_CS, test_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  bit discard = 1'b0;

  indikator2 #(.CLK_FREQ(10_000)) dut (
    .clk_in    (clk_in),
    .init_n    (init_n),
    .data      (data),
    .position  (position),
    .wrn       (wrn),
    .intensity (intensity),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_CLK   (SPI_CLK),
    .SPI_CS    (SPI_CS),
    .test_out  (test_out)
  );

  always #5 clk_in = ~clk_in;

  // Frame monitor, sampling on the falling edge.
  logic        prev_cs = 1'b1, prev_clk = 1'b0, prev_mosi = 1'b0;
  int          low_cnt = 0, rises = 0;
  logic [15:0] shreg = '0;
  logic [15:0] exp_w;

  always @(negedge clk_in) begin
    if (SPI_CS === 1'b0) begin
      if (prev_cs) begin
        low_cnt = 0;
        rises   = 0;
        shreg   = '0;
      end
      low_cnt++;
      if (SPI_CLK === 1'b1 && prev_clk === 1'b0) begin
        rises++;
        shreg = {shreg[14:0], SPI_MOSI};
        n_checks++;
        if (SPI_MOSI !== prev_mosi) begin
          n_fail++;
          $display("FAIL mosi_stable: got %b at SCLK rise, was %b in low phase", SPI_MOSI,
                   prev_mosi);
        end
      end
    end else if (SPI_CS === 1'b1 && prev_cs === 1'b0) begin
      if (discard) begin
        discard = 1'b0;
      end else begin
        n_checks += 4;
        if (low_cnt != 34) begin
          n_fail++;
          $display("FAIL cs_low_len: got %0d cycles, expected 34", low_cnt);
        end
        if (rises != 16) begin
          n_fail++;
          $display("FAIL sclk_rises: got %0d, expected 16", rises);
        end
        if (SPI_MOSI !== 1'b0) begin
          n_fail++;
          $display("FAIL mosi_idle: got %b with CS high, expected 0", SPI_MOSI);
        end
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_word: unexpected frame %h, none expected", shreg);
        end else begin
          exp_w = exp_q.pop_front();
          if (shreg !== exp_w) begin
            n_fail++;
            $display("FAIL frame_word: got %h, expected %h", shreg, exp_w);
          end
        end
      end
    end
    prev_cs   = SPI_CS;
    prev_clk  = SPI_CLK;
    prev_mosi = SPI_MOSI;
  end

  task automatic push_init(input logic [3:0] lvl);
    exp_q.push_back(16'h0C01);
    exp_q.push_back(16'h09FF);
    exp_q.push_back(16'h0B07);
    exp_q.push_back({12'h0A0, lvl});
    exp_q.push_back(16'h0F00);
  endtask

  task automatic write_digit(input logic [4:0] pos, input logic [3:0] d);
    position = pos;
    data     = d;
    wrn      = 1'b0;
    @(negedge clk_in);
    wrn = 1'b1;
  endtask

  // Counts CS-high cycles after reset release until the first frame begins.
  task automatic check_powerup_delay(input string name);
    int hi = 0;
    while (SPI_CS === 1'b1 && hi < 40) begin
      @(negedge clk_in);
      if (SPI_CS === 1'b1) hi++;
    end
    n_checks++;
    // Delay of 10 cycles plus a few cycles of FSM-to-shifter latency.
    if (hi < 10 || hi > 14) begin
      n_fail++;
      $display("FAIL %s: CS high for %0d cycles, expected 10..14", name, hi);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (!(exp_q.size() == 0 && test_out === 1'b0 && SPI_CS === 1'b1) && t < 3000) begin
      @(negedge clk_in);
      t++;
    end
    n_checks++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL %s: timeout, %0d frames outstanding, test_out=%b", name, exp_q.size(),
               test_out);
    end
  endtask

  task automatic wait_cs_low(input string name);
    int t = 0;
    while (SPI_CS !== 1'b0 && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    n_checks++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL %s: CS never fell, got %b expected 0", name, SPI_CS);
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit saw_cs = 1'b0, saw_busy = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_in);
      if (SPI_CS !== 1'b1) saw_cs = 1'b1;
      if (test_out !== 1'b0) saw_busy = 1'b1;
    end
    n_checks += 2;
    if (saw_cs) begin
      n_fail++;
      $display("FAIL %s_cs: got a frame, expected none", name);
    end
    if (saw_busy) begin
      n_fail++;
      $display("FAIL %s_busy: got test_out=1, expected 0", name);
    end
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    repeat (3) @(negedge clk_in);
    n_checks++;
    if ({SPI_CS, SPI_CLK, SPI_MOSI, test_out} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_outputs: got CS/CLK/MOSI/busy=%b, expected 1000",
               {SPI_CS, SPI_CLK, SPI_MOSI, test_out});
    end
    push_init(4'd2);
    init_n = 1'b1;
    check_powerup_delay("reset_delay");
    wait_idle("reset_init_seq");
  endtask

  task automatic test_write();
    exp_q.push_back(16'h0405);
    write_digit(5'd3, 4'd5);
    wait_idle("write_single");
    n_checks++;
    if (test_out !== 1'b0) begin
      n_fail++;
      $display("FAIL write_busy_after: got %b, expected 0", test_out);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(16'h0507);
    write_digit(5'd4, 4'd7);
    wait_cs_low("b2b_first_frame");
    repeat (3) @(negedge clk_in);
    position = 5'd0; data = 4'd1; wrn = 1'b0;
    @(negedge clk_in);
    position = 5'd1; data = 4'd2;
    @(negedge clk_in);
    position = 5'd2; data = 4'd9;
    @(negedge clk_in);
    wrn = 1'b1;
    n_checks++;
    if (SPI_CS !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_in_frame: got CS=%b during writes, expected 0", SPI_CS);
    end
    exp_q.push_back(16'h0309);
    wait_idle("b2b_latest_wins");
  endtask

  task automatic test_ignored();
    write_digit(5'd9, 4'd4);
    expect_quiet("ignored_pos", 60);
  endtask

  task automatic test_intensity();
    exp_q.push_back(16'h0A0F);
    intensity = 4'd15;
    wait_idle("intensity_change");
    intensity = 4'd15;
    expect_quiet("intensity_same", 60);
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(16'h0506);
    write_digit(5'd4, 4'd6);
    wait_cs_low("mid_frame_start");
    repeat (10) @(negedge clk_in);
    discard = 1'b1;
    exp_q.delete();
    init_n = 1'b0;
    @(negedge clk_in);
    init_n = 1'b1;
    n_checks++;
    if ({SPI_CS, SPI_CLK, SPI_MOSI, test_out} !== 4'b1000) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got CS/CLK/MOSI/busy=%b, expected 1000",
               {SPI_CS, SPI_CLK, SPI_MOSI, test_out});
    end
    push_init(4'd15);
    check_powerup_delay("mid_reset_delay");
    wait_idle("mid_reset_init_seq");
  endtask

  initial begin
    init_n    = 1'b0;
    wrn       = 1'b1;
    data      = '0;
    position  = '0;
    intensity = 4'd2;
    @(negedge clk_in);
    test_reset();
    test_write();
    test_back_to_back();
    test_ignored();
    test_intensity();
    test_reset_mid();
    repeat (5) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
